// File: rtl/fp16_addsub_sequencer.sv
// fp16_addsub_sequencer
// Multi-cycle IEEE-754 binary16 add/subtract controller. It accepts one
// operation at a time and steps it through unpack, align, add, normalize and
// round. A 14-bit carry-lookahead adder is used only in the ADD state.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operation (high only in IDLE)
//   a, b       binary16 operands
//   op         0 = a+b, 1 = a-b
//   out_valid  result valid (high only in DONE)
//   out_ready  sink accepts the result
//   result     binary16 result; updated only when DONE is entered
//   busy       high in every state except IDLE
//
// Internal mantissa layout (MW=14): hidden(13) fraction(12:3) guard(2)
// round(1) sticky(0).
module fp16_addsub_sequencer #(
   parameter int          MW   = 14,
   parameter logic [15:0] QNAN = 16'h7E00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_ROUND  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t        state_r, state_nx_s;
   logic [15:0]   opa_r, opb_r;
   logic          sub_op_r, sign_r, eff_sub_r;
   logic [5:0]    exp_r, dexp_r;
   logic [MW-1:0] mant_a_r, mant_b_r;
   logic          in_ready_s, out_valid_s, busy_s;

   // Carry-lookahead adder: generate/propagate with lookahead carry recurrence.
   // sub=1 forms x + ~y + 1.
   function automatic logic [MW:0] cla_add(input logic [MW-1:0] x,
                                           input logic [MW-1:0] y,
                                           input logic          sub);
      logic [MW-1:0] yy, g, p;
      logic [MW:0]   c;
      yy   = sub ? ~y : y;
      g    = x & yy;
      p    = x ^ yy;
      c[0] = sub;
      for (int i = 0; i < MW; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[MW], p ^ c[MW-1:0]};
   endfunction

   // Unpack: classify operands, order by magnitude, build special results.
   logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s, special_s, swap_s;
   logic [14:0] big_mag_s, small_mag_s;
   logic [5:0]  exp_big_s, exp_small_s;
   logic [15:0] special_val_s;
   always_comb begin
      nan_a_s     = (opa_r[14:10] == 5'h1F) && (opa_r[9:0] != 10'h000);
      nan_b_s     = (opb_r[14:10] == 5'h1F) && (opb_r[9:0] != 10'h000);
      inf_a_s     = (opa_r[14:10] == 5'h1F) && (opa_r[9:0] == 10'h000);
      inf_b_s     = (opb_r[14:10] == 5'h1F) && (opb_r[9:0] == 10'h000);
      special_s   = nan_a_s | nan_b_s | inf_a_s | inf_b_s;
      swap_s      = (opb_r[14:0] > opa_r[14:0]);
      big_mag_s   = swap_s ? opb_r[14:0] : opa_r[14:0];
      small_mag_s = swap_s ? opa_r[14:0] : opb_r[14:0];
      // Subnormals use effective exponent 1 with a zero hidden bit.
      exp_big_s   = (big_mag_s[14:10] == 5'h00) ? 6'd1 : {1'b0, big_mag_s[14:10]};
      exp_small_s = (small_mag_s[14:10] == 5'h00) ? 6'd1 : {1'b0, small_mag_s[14:10]};
      if (nan_a_s || nan_b_s) begin
         special_val_s = QNAN;
      end else if (inf_a_s && inf_b_s && (opa_r[15] ^ opb_r[15] ^ sub_op_r)) begin
         special_val_s = QNAN;
      end else if (inf_a_s) begin
         special_val_s = opa_r;
      end else if (inf_b_s) begin
         special_val_s = {opb_r[15] ^ sub_op_r, opb_r[14:0]};
      end else begin
         special_val_s = 16'h0000;
      end
   end

   // Align: right-shift the smaller mantissa, folding lost bits into sticky.
   logic [3:0]    sh_s;
   logic [MW-1:0] shifted_s, lost_mask_s, aligned_s;
   always_comb begin
      sh_s        = (dexp_r > 6'd14) ? 4'd14 : dexp_r[3:0];
      shifted_s   = mant_b_r >> sh_s;
      lost_mask_s = ~({MW{1'b1}} << sh_s);
      aligned_s   = {shifted_s[MW-1:1], shifted_s[0] | (|(mant_b_r & lost_mask_s))};
   end

   // Add: a carry on effective addition renormalizes right by one, keeping sticky.
   logic [MW:0]   cla_s;
   logic          carry_s, zero_s;
   logic [MW-1:0] sum_mant_s;
   logic [5:0]    sum_exp_s;
   always_comb begin
      cla_s   = cla_add(mant_a_r, mant_b_r, eff_sub_r);
      carry_s = cla_s[MW] & ~eff_sub_r;
      zero_s  = (cla_s[MW-1:0] == {MW{1'b0}}) && !carry_s;
      if (carry_s) begin
         sum_mant_s = {1'b1, cla_s[MW-1:2], cla_s[1] | cla_s[0]};
         sum_exp_s  = exp_r + 6'd1;
      end else begin
         sum_mant_s = cla_s[MW-1:0];
         sum_exp_s  = exp_r;
      end
   end

   // Normalize: shift left while the hidden bit is clear and exponent allows.
   logic norm_shift_s;
   always_comb begin
      norm_shift_s = !mant_a_r[MW-1] && (exp_r > 6'd1);
   end

   // Round to nearest even on guard/round/sticky and pack the result.
   logic        rnd_up_s;
   logic [11:0] rnd_s;
   logic [5:0]  rnd_exp_s;
   logic [15:0] round_val_s;
   always_comb begin
      rnd_up_s  = mant_a_r[2] & (mant_a_r[3] | mant_a_r[1] | mant_a_r[0]);
      rnd_s     = {1'b0, mant_a_r[MW-1:3]} + {11'd0, rnd_up_s};
      rnd_exp_s = exp_r + {5'd0, rnd_s[11]};
      if (rnd_exp_s >= 6'd31) begin
         round_val_s = {sign_r, 5'h1F, 10'h000};
      end else if (rnd_s[11]) begin
         round_val_s = {sign_r, rnd_exp_s[4:0], rnd_s[10:1]};
      end else if (rnd_s[10]) begin
         // Includes a subnormal that rounded up into the hidden bit (exp 1).
         round_val_s = {sign_r, rnd_exp_s[4:0], rnd_s[9:0]};
      end else begin
         round_val_s = {sign_r, 5'h00, rnd_s[9:0]};
      end
   end

   // State register plus registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         in_ready  <= in_ready_s;
         out_valid <= out_valid_s;
         busy      <= busy_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid && in_ready) state_nx_s = S_UNPACK;
            else                      state_nx_s = S_IDLE;
         end
         S_UNPACK: state_nx_s = special_s ? S_DONE : S_ALIGN;
         S_ALIGN:  state_nx_s = S_ADD;
         S_ADD:    state_nx_s = zero_s ? S_DONE : S_NORM;
         S_NORM:   state_nx_s = norm_shift_s ? S_NORM : S_ROUND;
         S_ROUND:  state_nx_s = S_DONE;
         S_DONE: begin
            if (out_ready) state_nx_s = S_IDLE;
            else           state_nx_s = S_DONE;
         end
         default:  state_nx_s = S_IDLE;
      endcase
   end

   // Output decode from the next state so the outputs come straight from flops.
   always_comb begin
      in_ready_s  = (state_nx_s == S_IDLE);
      out_valid_s = (state_nx_s == S_DONE);
      busy_s      = (state_nx_s != S_IDLE);
   end

   // Datapath registers; result is written only on the transition into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_r     <= 16'h0000;
         opb_r     <= 16'h0000;
         sub_op_r  <= 1'b0;
         sign_r    <= 1'b0;
         eff_sub_r <= 1'b0;
         exp_r     <= 6'd0;
         dexp_r    <= 6'd0;
         mant_a_r  <= {MW{1'b0}};
         mant_b_r  <= {MW{1'b0}};
         result    <= 16'h0000;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  opa_r    <= a;
                  opb_r    <= b;
                  sub_op_r <= op;
               end
            end
            S_UNPACK: begin
               mant_a_r  <= {big_mag_s[14:10] != 5'h00, big_mag_s[9:0], 3'b000};
               mant_b_r  <= {small_mag_s[14:10] != 5'h00, small_mag_s[9:0], 3'b000};
               exp_r     <= exp_big_s;
               dexp_r    <= exp_big_s - exp_small_s;
               sign_r    <= swap_s ? (opb_r[15] ^ sub_op_r) : opa_r[15];
               eff_sub_r <= opa_r[15] ^ opb_r[15] ^ sub_op_r;
               if (special_s) result <= special_val_s;
            end
            S_ALIGN: mant_b_r <= aligned_s;
            S_ADD: begin
               mant_a_r <= sum_mant_s;
               exp_r    <= sum_exp_s;
               // Exact zero is +0, except -0 + -0 under effective addition.
               if (zero_s) result <= {sign_r & ~eff_sub_r, 15'h0000};
            end
            S_NORM: begin
               if (norm_shift_s) begin
                  mant_a_r <= mant_a_r << 1;
                  exp_r    <= exp_r - 6'd1;
               end
            end
            S_ROUND: result <= round_val_s;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_addsub_sequencer.sv
module tb_fp16_addsub_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] spec_tab [0:9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                                   16'h7C01, 16'h0001, 16'h03FF, 16'h0400, 16'h7BFF};

   fp16_addsub_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic real pow2(input int k);
      real r;
      r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      real v;
      int  e, f;
      e = int'(h[14:10]);
      f = int'(h[9:0]);
      if (e == 0) v = $itor(f) * pow2(-24);
      else        v = $itor(f + 1024) * pow2(e - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic bit is_nan(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] != 10'h000);
   endfunction

   function automatic bit is_inf(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] == 10'h000);
   endfunction

   // Exact sum in double precision, then round-to-nearest-even into binary16.
   function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y, input logic sub);
      logic [15:0] yy;
      real         s, m, n;
      int          e, fi;
      logic        sg;
      yy = {y[15] ^ sub, y[14:0]};
      if (is_nan(x) || is_nan(y)) return 16'h7E00;
      if (is_inf(x) && is_inf(yy)) return (x[15] == yy[15]) ? x : 16'h7E00;
      if (is_inf(x)) return x;
      if (is_inf(yy)) return yy;
      s = h2r(x) + h2r(yy);
      if (s == 0.0) return {x[15] & yy[15], 15'h0000};
      sg = (s < 0.0);
      m  = sg ? -s : s;
      e  = -14;
      while (m >= pow2(e + 1)) e++;
      n  = m / pow2(e - 10);
      fi = $rtoi(n);
      if (((n - $itor(fi)) > 0.5) || (((n - $itor(fi)) == 0.5) && fi[0])) fi++;
      if (fi == 2048) begin
         e++;
         fi = 1024;
      end
      if (e > 15) return {sg, 15'h7C00};
      if (fi < 1024) return {sg, 5'd0, fi[9:0]};
      return {sg, 5'(e + 15), fi[9:0]};
   endfunction

   function automatic logic [15:0] rnd_half(input logic [15:0] near);
      logic [15:0] r;
      int          sel, e;
      r   = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
         r = spec_tab[$urandom_range(0, 9)];
      end else if (sel <= 4) begin
         e = int'(near[14:10]) + int'($urandom_range(0, 2)) - 1;
         if (e < 0) e = 0;
         if (e > 30) e = 30;
         r[14:10] = 5'(e);
      end else if (sel == 5) begin
         r[14:10] = 5'd0;
      end
      return r;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            fail_now("spurious_out_valid");
         end else begin
            chk("result", 32'(result), 32'(exp_q[0]));
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      ok = in_ready;
      if (!ok) fail_now("in_ready_timeout");
   endtask

   task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                        input int lat, input int hold,
                        input logic [15:0] lit, input bit use_lit);
      logic [15:0] ex;
      int          n;
      bit          seen, ok;
      ex = model(xa, xb, xop);
      if (use_lit) chk("model_pin", 32'(ex), 32'(lit));
      out_ready = (hold == 0) ? 1'b1 : 1'b0;
      wait_ready(ok);
      if (!ok) return;
      a = xa; b = xb; op = xop; in_valid = 1'b1;
      exp_q.push_back(use_lit ? lit : ex);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_after_accept", 32'(in_ready), 32'd0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1'b1;
      end
      if (!seen) begin
         fail_now("out_valid_timeout");
         exp_q.delete();
         out_ready = 1'b1;
         return;
      end
      if (lat >= 0) chk("latency", 32'(n), 32'(lat));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         if (i == hold - 1) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end else begin
            in_valid = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
         end
      end
      @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      bit          ok;
      logic [15:0] xa, xb;
      rst_n = 1'b0; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; op = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'h0000);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op(16'h3C00, 16'h3C00, 1'b0, 6, 0, 16'h4000, 1'b1);

      // Abort during normalization of 1.0 - 0.99951: reset clears everything.
      wait_ready(ok);
      a = 16'h3C00; b = 16'h3BFF; op = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("busy_in_norm", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_result", 32'(result), 32'h0000);
      chk("abort_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op(16'h3C00, 16'h3C00, 1'b0, 6, 0, 16'h4000, 1'b1);
      do_op(16'h3C00, 16'h3BFF, 1'b1, 17, 0, 16'h1000, 1'b1);
      do_op(16'h3C00, 16'h1000, 1'b0, 6, 0, 16'h3C00, 1'b1);
      do_op(16'h3C01, 16'h1000, 1'b0, 6, 0, 16'h3C02, 1'b1);
      do_op(16'h7BFF, 16'h7BFF, 1'b0, 6, 0, 16'h7C00, 1'b1);
      do_op(16'h7C00, 16'h7C00, 1'b1, 2, 0, 16'h7E00, 1'b1);
      do_op(16'h7C01, 16'h3C00, 1'b0, 2, 0, 16'h7E00, 1'b1);
      do_op(16'h3C00, 16'h3C00, 1'b1, 4, 0, 16'h0000, 1'b1);
      do_op(16'h0001, 16'h0001, 1'b0, 6, 0, 16'h0002, 1'b1);
      do_op(16'h8000, 16'h8000, 1'b0, 4, 0, 16'h8000, 1'b1);
      do_op(16'h4000, 16'h3C00, 1'b0, 6, 10, 16'h4200, 1'b1);

      xa = 16'h3C00;
      for (int i = 0; i < 300; i++) begin
         xa = rnd_half(xa);
         xb = rnd_half(xa);
         do_op(xa, xb, 1'($urandom), -1, int'($urandom_range(0, 3)), 16'h0000, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fp16_addsub_sequencer.md
Name: fp16_addsub_sequencer

Overview:
Multi-cycle IEEE-754 binary16 add/subtract controller that sequences the shared parameterized carry-lookahead adder (CLAPARAMETER, N=14) through unpack, align, add, normalize and round phases. It sits between the operand source and the result sink of the half-precision FP unit, using a valid/ready handshake on both sides. One operation is in flight at a time, and the adder is driven only in the ADD state.

Parameters:
MW, 14, internal mantissa width: hidden(13), fraction(12:3), guard(2), round(1), sticky(0); fixed by CLA width
QNAN, 16'h7E00, canonical NaN emitted for every NaN result

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operation (IDLE only)
a  in  16  operand A, binary16
b  in  16  operand B, binary16
op  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
result  out  16  binary16 result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=16'h0000, busy=0, all internal registers cleared. Reset mid-operation aborts the operation with no output.
- States: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, capture a, b, op -> UNPACK. in_valid is ignored in all other states.
- UNPACK (1 cycle):
  - Exponent field 0 -> hidden bit 0, effective exponent 1 (subnormal).
  - Specials -> DONE with result set:
    - any NaN -> QNAN
    - Inf op Inf with effective subtract -> QNAN
    - a single Inf -> that Inf, sign adjusted for op on B
  - Otherwise swap so |A| >= |B| (compare {exp, frac}).
  - sign_r = sign of larger operand, with B's sign inverted when op=1.
  - eff_sub = sa ^ sb ^ op.
  - d = expA - expB.
  - -> ALIGN.
- ALIGN (1 cycle): B mantissa shifted right by min(d,14); shifted-out bits ORed into sticky. -> ADD.
- ADD (1 cycle): CLA A=mantA, B=mantB, opCode=eff_sub.
  - eff_add with Cout=1: shift right 1, keep sticky, exp+1.
  - eff_sub: Cout ignored (no borrow possible since |A|>=|B|).
  - Sum == 0: result = +0 -> DONE. Exception: -0 when both effective operands are -0 under eff_add.
  - Otherwise -> NORM.
- NORM: each cycle, if bit13=0 and exp>1, shift left 1 and exp-1; otherwise -> ROUND. Exit occurs with zero shifts when already normalized. Maximum 13 shift cycles. Stopping at exp=1 with bit13=0 yields a subnormal encoding (exp field 0).
- ROUND (1 cycle): round-to-nearest-even on guard/round/sticky.
  - Mantissa carry-out -> exp+1.
  - exp >= 31 -> Inf with sign_r.
  - Subnormal rounding up into bit13 -> exp field 1.
  - -> DONE.
- DONE: out_valid=1, result stable. When out_ready=1 -> IDLE next cycle, out_valid deasserts. While out_ready=0, the state is held indefinitely.
- Latency, counted from the accept cycle = 0:
  - normal path: out_valid high at cycle 6+k, where k = NORM shift count
  - special/NaN/Inf path: cycle 2
  - zero-sum path: cycle 4
- Back-to-back: the earliest new accept is the cycle after the DONE handshake. Throughput is therefore at most 1 op per (7+k) cycles.
- result changes only on DONE entry. It holds its last value in IDLE.

Test Plan:
- Reset during NORM of 0x3C00-0x3BFF -> immediately out_valid=0, in_ready=1, result=0x0000. A following 0x3C00+0x3C00 completes correctly.
- 0x3C00+0x3C00, op=0, out_ready=1 -> result 0x4000, out_valid at cycle 6, in_ready at cycle 7.
- 0x3C00 op=1 0x3BFF -> 0x1000, k=11, out_valid at cycle 17.
- Rounding ties: 0x3C00+0x1000 -> 0x3C00; 0x3C01+0x1000 -> 0x3C02; 0x7BFF+0x7BFF -> 0x7C00 (overflow to +Inf).
- Specials: 0x7C00 op=1 0x7C00 -> 0x7E00 at cycle 2; 0x7C01+0x3C00 -> 0x7E00; 0x3C00 op=1 0x3C00 -> 0x0000 at cycle 4; 0x0001+0x0001 -> 0x0002 (subnormal).
- Backpressure: out_ready=0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0. in_valid pulses during this window are ignored. out_ready=1 -> IDLE next cycle.
